// File: rtl/soc_ram64.sv
// soc_ram64 -- word-organised 64-bit data RAM on the CPU memory bus.
//
// Serves CPU loads and stores. Writes are shifted left by `shift` and then
// merged lane by lane under `mask`. Reads return the addressed word shifted
// right by `shift`, registered for one cycle, and driven onto the shared bus.
//
// Ports:
//   clk     in     system clock, all state changes on the rising edge
//   reset   in     synchronous, active-low reset (clears the read register only)
//   addr    in     word address (CPU byte address bits [13:3])
//   data    inout  shared data bus: CPU drives on writes, RAM drives on reads
//   mask    in     byte-lane write enables, bit i covers data[8i+7:8i]
//   shift   in     bit shift amount 0..63
//   rw      in     1 = write cycle, 0 = read cycle
//   enable  in     RAM selected; 0 = no access and bus released
//
// Every word starts at 0 at time zero. Reset never reinitialises the array.
//
// DATA_W must be 64 (eight byte lanes).

module soc_ram64 #(
    parameter int    ADDR_W    = 11,
    parameter int    DATA_W    = 64,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    input  logic [7:0]        mask,
    input  logic [5:0]        shift,
    input  logic              rw,
    input  logic              enable
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;

    // Declaration-time zero fill gives "all words start at 0".
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    localparam bit init_file_unused = (INIT_FILE != "");

    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] wshift;
    logic              we;
    logic              re;

    always_comb begin
        we      = reset && enable && rw;
        re      = reset && enable && !rw;
        wshift  = data << shift;
        rdata_d = rdata_q;
        if (!reset) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem[addr] >> shift;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    // Storage has no reset: contents survive reset, and a write pending in a
    // reset cycle is dropped because we is qualified by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mask[i]) begin
                    mem[addr][8*i +: 8] <= wshift[8*i +: 8];
                end
            end
        end
    end

    // Bus is driven only while a read is selected; released otherwise.
    assign data = (enable && !rw) ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_soc_ram64.sv
module tb_soc_ram64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] addr = '0;
    logic [7:0]  mask = '0;
    logic [5:0]  shift = '0;
    logic        rw = 1'b0;
    logic        enable = 1'b1;
    logic        tb_oe = 1'b0;
    logic [63:0] tb_wdata = '0;
    wire  [63:0] data;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: flat byte array, byte k of word a at index a*8+k.
    byte unsigned mb [2048*8];

    assign data = tb_oe ? tb_wdata : 64'bz;

    soc_ram64 dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .data   (data),
        .mask   (mask),
        .shift  (shift),
        .rw     (rw),
        .enable (enable)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_word(input int a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = mb[a*8 + k];
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One write-type cycle; bus must carry exactly what the bench drives.
    task automatic do_write(input logic [10:0] a, input logic [63:0] d, input logic [7:0] m,
                            input logic [5:0] sh, input logic en, input logic rst_n,
                            input string tag);
        logic [63:0] shifted;
        @(negedge clk);
        reset = rst_n; enable = en; rw = 1'b1; addr = a; mask = m; shift = sh;
        tb_wdata = d; tb_oe = 1'b1;
        @(posedge clk);
        #1;
        if (en && rst_n) begin
            shifted = d << sh;
            for (int k = 0; k < 8; k++)
                if (m[k]) mb[int'(a)*8 + k] = shifted[8*k +: 8];
        end
        check(tag, data, d);
    endtask

    task automatic do_read(input logic [10:0] a, input logic [5:0] sh, input string tag,
                           output logic [63:0] obs);
        logic [63:0] exp;
        @(negedge clk);
        reset = 1'b1; enable = 1'b1; rw = 1'b0; addr = a; shift = sh;
        mask = 8'($urandom); tb_oe = 1'b0;
        @(posedge clk);
        #1;
        exp = model_word(int'(a)) >> sh;
        obs = data;
        check(tag, obs, exp);
    endtask

    // Deselected cycle with the bench pulling the bus to zero: any RAM drive shows up.
    task automatic do_idle(input string tag);
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; rw = 1'b0; tb_wdata = '0; tb_oe = 1'b1;
        @(posedge clk);
        #1;
        check(tag, data, 64'h0);
    endtask

    initial begin
        logic [63:0] obs;
        logic [10:0] a;
        logic [63:0] d;
        int op;

        // Reset held with a read selected: RAM drives the cleared read register.
        @(posedge clk); #1;
        check("reset_cycle1", data, 64'h0);
        @(posedge clk); #1;
        check("reset_cycle2", data, 64'h0);
        do_read(11'd5, 6'd0, "read_after_init", obs);
        check("read_after_init_const", obs, 64'h0);

        // Full write then read.
        do_write(11'h123, 64'h0123_4567_89AB_CDEF, 8'hFF, 6'd0, 1'b1, 1'b1, "wr_full_bus");
        do_read(11'h123, 6'd0, "rd_full", obs);
        check("rd_full_const", obs, 64'h0123_4567_89AB_CDEF);

        // Byte-masked shifted write into lane 2.
        do_write(11'h123, 64'hAA, 8'h04, 6'd16, 1'b1, 1'b1, "wr_lane2_bus");
        do_read(11'h123, 6'd0, "rd_lane2_sh0", obs);
        check("rd_lane2_sh0_const", obs, 64'h0123_4567_89AA_CDEF);
        do_read(11'h123, 6'd16, "rd_lane2_sh16", obs);
        check("rd_lane2_sh16_const", obs, 64'h0000_0123_4567_89AA);

        // Bus released while deselected (read register currently non-zero).
        do_idle("bus_release_idle");

        // Zero mask and disabled writes leave contents unchanged.
        do_write(11'h123, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 6'd0, 1'b1, 1'b1, "wr_mask0_bus");
        do_write(11'h123, 64'h5555_5555_5555_5555, 8'hFF, 6'd0, 1'b0, 1'b1, "wr_disabled_bus");
        do_read(11'h123, 6'd0, "rd_unchanged", obs);
        check("rd_unchanged_const", obs, 64'h0123_4567_89AA_CDEF);

        // Reset during a selected read clears the read register.
        @(negedge clk);
        reset = 1'b0; enable = 1'b1; rw = 1'b0; tb_oe = 1'b0;
        @(posedge clk); #1;
        check("reset_clears_rdata", data, 64'h0);

        // Reset during a write drops the write.
        do_write(11'd7, 64'h1111_2222_3333_4444, 8'hFF, 6'd0, 1'b1, 1'b1, "wr_addr7_bus");
        do_write(11'd7, 64'hDEAD, 8'hFF, 6'd0, 1'b1, 1'b0, "wr_in_reset_bus");
        do_read(11'd7, 6'd0, "rd_addr7", obs);
        check("rd_addr7_const", obs, 64'h1111_2222_3333_4444);

        // Boundary addresses.
        do_write(11'd0, 64'h1, 8'hFF, 6'd0, 1'b1, 1'b1, "wr_addr0_bus");
        do_write(11'd2047, 64'h2, 8'hFF, 6'd0, 1'b1, 1'b1, "wr_addr2047_bus");
        do_read(11'd0, 6'd0, "rd_addr0", obs);
        check("rd_addr0_const", obs, 64'h1);
        do_read(11'd2047, 6'd0, "rd_addr2047", obs);
        check("rd_addr2047_const", obs, 64'h2);

        // Randomized mix against the byte model.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: a = 11'd0;
                1: a = 11'h7FF;
                default: a = 11'h120 + 11'($urandom_range(0, 7));
            endcase
            d = {$urandom, $urandom};
            op = $urandom_range(0, 4);
            case (op)
                0, 1: do_write(a, d, 8'($urandom), 6'($urandom_range(0, 63)), 1'b1, 1'b1, "rnd_wr_bus");
                2, 3: do_read(a, 6'($urandom_range(0, 63)), "rnd_rd", obs);
                default: begin
                    do_write(a, d, 8'hFF, 6'd0, 1'b0, 1'b1, "rnd_disabled_bus");
                    do_idle("rnd_idle");
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
